// File: rtl/rr_process_scheduler.sv
// ---------------------------------------------------------------------------
// rr_process_scheduler
//
// Round-robin process scheduler with a per-slot quantum timer. Each of the
// NUM_PROC slots holds a process state and a saved PC. On every dispatch the
// scheduler issues a one-cycle PC-load command to the CPU's PC register.
//
// Ports
//   clock, reset       : system clock, synchronous active-high reset
//   create_valid/_id/_pc : create a READY process in a slot with an initial PC
//   start              : leave IDLE and begin scheduling
//   quantum_cfg        : quantum length in retired instructions (0 acts as 1)
//   instr_retire       : running process retired one instruction
//   retire_pc          : PC of the next instruction of the running process
//   io_block           : running process blocks on I/O (saves retire_pc)
//   proc_exit          : running process terminates
//   io_wake/_id        : I/O completion for a BLOCKED slot
//   load_pc_valid/load_pc : one-cycle PC-load command for the dispatched process
//   current_id         : running or most recently run slot
//   running/waiting/all_done : FSM in RUN / WAIT / DONE
// ---------------------------------------------------------------------------
module rr_process_scheduler #(
   parameter  int NUM_PROC = 8,
   parameter  int PC_W     = 32,
   parameter  int Q_W      = 8,
   localparam int ID_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            create_valid,
   input  logic [ID_W-1:0] create_id,
   input  logic [PC_W-1:0] create_pc,
   input  logic            start,
   input  logic [Q_W-1:0]  quantum_cfg,
   input  logic            instr_retire,
   input  logic [PC_W-1:0] retire_pc,
   input  logic            io_block,
   input  logic            proc_exit,
   input  logic            io_wake,
   input  logic [ID_W-1:0] io_wake_id,
   output logic            load_pc_valid,
   output logic [PC_W-1:0] load_pc,
   output logic [ID_W-1:0] current_id,
   output logic            running,
   output logic            waiting,
   output logic            all_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_DISPATCH, S_RUN, S_WAIT, S_DONE
   } fsm_e;

   typedef enum logic [2:0] {
      SL_EMPTY, SL_READY, SL_RUNNING, SL_BLOCKED, SL_FINISHED
   } slot_e;

   fsm_e            state_q;
   slot_e           slot_q     [NUM_PROC];
   logic [PC_W-1:0] saved_pc_q [NUM_PROC];
   logic [ID_W-1:0] cur_q;
   logic [Q_W-1:0]  qcnt_q;
   logic            first_q;
   logic            load_pc_valid_q;
   logic [PC_W-1:0] load_pc_q;

   // Combinational search / event qualification
   int              base_i;
   logic [ID_W-1:0] idx_d;
   logic [ID_W-1:0] sel_id_d;
   logic            sel_found_d;
   logic            any_ready_d;
   logic            any_blocked_d;
   logic [Q_W-1:0]  q_load_d;
   logic            wake_hit_d;
   logic            create_ok_d;
   logic            expire_d;

   // Round-robin search. Before the first dispatch the search starts at slot 0
   // so the lowest created slot runs first; afterwards it starts just past
   // current_id and ends at current_id itself. The loop runs from the farthest
   // position down so the nearest READY slot is the one left in sel_id_d.
   always_comb begin
      base_i      = first_q ? (NUM_PROC - 1) : int'(cur_q);
      idx_d       = '0;
      sel_id_d    = '0;
      sel_found_d = 1'b0;
      for (int i = NUM_PROC; i >= 1; i--) begin
         idx_d = ID_W'((base_i + i) % NUM_PROC);
         if (slot_q[idx_d] == SL_READY) begin
            sel_found_d = 1'b1;
            sel_id_d    = idx_d;
         end
      end
   end

   always_comb begin
      any_ready_d   = 1'b0;
      any_blocked_d = 1'b0;
      for (int j = 0; j < NUM_PROC; j++) begin
         if (slot_q[ID_W'(j)] == SL_READY)   any_ready_d   = 1'b1;
         if (slot_q[ID_W'(j)] == SL_BLOCKED) any_blocked_d = 1'b1;
      end
   end

   assign q_load_d    = (quantum_cfg == '0) ? Q_W'(1) : quantum_cfg;
   assign wake_hit_d  = io_wake && (state_q != S_IDLE) &&
                        (slot_q[io_wake_id] == SL_BLOCKED);
   assign create_ok_d = create_valid && (state_q != S_DONE) &&
                        (slot_q[create_id] != SL_RUNNING);
   assign expire_d    = (qcnt_q == Q_W'(1)) || (qcnt_q == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= S_IDLE;
         slot_q          <= '{default: SL_EMPTY};
         saved_pc_q      <= '{default: '0};
         cur_q           <= '0;
         qcnt_q          <= '0;
         first_q         <= 1'b1;
         load_pc_valid_q <= 1'b0;
         load_pc_q       <= '0;
      end else begin
         load_pc_valid_q <= 1'b0;

         // Slot-table side effects; FSM updates below are written later so
         // they win when they touch the same slot in the same cycle.
         if (wake_hit_d) slot_q[io_wake_id] <= SL_READY;
         if (create_ok_d) begin
            slot_q[create_id]     <= SL_READY;
            saved_pc_q[create_id] <= create_pc;
         end

         case (state_q)
            S_IDLE: begin
               if (start) state_q <= (any_ready_d || create_ok_d) ? S_SELECT : S_DONE;
            end
            S_SELECT: begin
               if (sel_found_d) begin
                  cur_q            <= sel_id_d;
                  first_q          <= 1'b0;
                  slot_q[sel_id_d] <= SL_RUNNING;
                  qcnt_q           <= q_load_d;
                  load_pc_valid_q  <= 1'b1;
                  // A create landing on the chosen slot this cycle supplies the PC.
                  load_pc_q        <= (create_ok_d && (create_id == sel_id_d)) ?
                                      create_pc : saved_pc_q[sel_id_d];
                  state_q          <= S_DISPATCH;
               end else if (wake_hit_d || create_ok_d) begin
                  // A slot becomes READY this edge; search again next cycle.
                  state_q <= S_SELECT;
               end else if (any_blocked_d) begin
                  state_q <= S_WAIT;
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_DISPATCH: begin
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (proc_exit) begin
                  slot_q[cur_q] <= SL_FINISHED;
                  state_q       <= S_SELECT;
               end else if (io_block) begin
                  slot_q[cur_q]     <= SL_BLOCKED;
                  saved_pc_q[cur_q] <= retire_pc;
                  state_q           <= S_SELECT;
               end else if (instr_retire) begin
                  qcnt_q <= qcnt_q - Q_W'(1);
                  if (expire_d) begin
                     slot_q[cur_q]     <= SL_READY;
                     saved_pc_q[cur_q] <= retire_pc;
                     state_q           <= S_SELECT;
                  end
               end
            end
            S_WAIT: begin
               if (wake_hit_d || create_ok_d) state_q <= S_SELECT;
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign load_pc_valid = load_pc_valid_q;
   assign load_pc       = load_pc_q;
   assign current_id    = cur_q;
   assign running       = (state_q == S_RUN);
   assign waiting       = (state_q == S_WAIT);
   assign all_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rr_process_scheduler.sv
module tb_rr_process_scheduler;

   localparam int NUM_PROC = 8;
   localparam int PC_W     = 32;
   localparam int Q_W      = 8;
   localparam int ID_W     = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            create_valid;
   logic [ID_W-1:0] create_id;
   logic [PC_W-1:0] create_pc;
   logic            start;
   logic [Q_W-1:0]  quantum_cfg;
   logic            instr_retire;
   logic [PC_W-1:0] retire_pc;
   logic            io_block;
   logic            proc_exit;
   logic            io_wake;
   logic [ID_W-1:0] io_wake_id;
   logic            load_pc_valid;
   logic [PC_W-1:0] load_pc;
   logic [ID_W-1:0] current_id;
   logic            running;
   logic            waiting;
   logic            all_done;

   rr_process_scheduler #(
      .NUM_PROC(NUM_PROC), .PC_W(PC_W), .Q_W(Q_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .create_valid (create_valid),
      .create_id    (create_id),
      .create_pc    (create_pc),
      .start        (start),
      .quantum_cfg  (quantum_cfg),
      .instr_retire (instr_retire),
      .retire_pc    (retire_pc),
      .io_block     (io_block),
      .proc_exit    (proc_exit),
      .io_wake      (io_wake),
      .io_wake_id   (io_wake_id),
      .load_pc_valid(load_pc_valid),
      .load_pc      (load_pc),
      .current_id   (current_id),
      .running      (running),
      .waiting      (waiting),
      .all_done     (all_done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [PC_W-1:0] pc;
   } disp_t;

   disp_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      create_valid = 1'b0; create_id = '0; create_pc = '0;
      start = 1'b0; instr_retire = 1'b0; retire_pc = '0;
      io_block = 1'b0; proc_exit = 1'b0; io_wake = 1'b0; io_wake_id = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic create(input int id, input int pc);
      create_valid = 1'b1; create_id = ID_W'(id); create_pc = PC_W'(pc);
      cyc();
      create_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic retire(input int pc);
      instr_retire = 1'b1; retire_pc = PC_W'(pc);
      cyc();
      instr_retire = 1'b0;
   endtask

   task automatic push(input int id, input int pc);
      disp_t d;
      d.id = ID_W'(id);
      d.pc = PC_W'(pc);
      exp_q.push_back(d);
   endtask

   // Called right after the edge that sampled the triggering event:
   // the PC-load pulse must appear exactly one edge later, for one cycle.
   task automatic check_dispatch(input string tag);
      disp_t e;
      chk({tag, "_select_vld"}, 64'(load_pc_valid), 64'd0);
      cyc();
      chk({tag, "_vld"}, 64'(load_pc_valid), 64'd1);
      chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_pc"}, 64'(load_pc), 64'(e.pc));
         chk({tag, "_id"}, 64'(current_id), 64'(e.id));
      end
      cyc();
      chk({tag, "_pulse_end"}, 64'(load_pc_valid), 64'd0);
      chk({tag, "_running"}, 64'(running), 64'd1);
   endtask

   initial begin
      quantum_cfg = 8'd3;
      do_reset();

      // Reset state
      chk("rst_vld",     64'(load_pc_valid), 64'd0);
      chk("rst_pc",      64'(load_pc),       64'd0);
      chk("rst_id",      64'(current_id),    64'd0);
      chk("rst_running", 64'(running),       64'd0);
      chk("rst_waiting", 64'(waiting),       64'd0);
      chk("rst_done",    64'(all_done),      64'd0);

      // Round robin across three slots, quantum 3
      create(0, 100); create(1, 200); create(2, 300);
      quantum_cfg = 8'd3;
      push(0, 100);
      start_pulse();
      check_dispatch("rr_d0");
      retire(101); retire(102);
      chk("rr_no_early_preempt", 64'(running), 64'd1);
      push(1, 200); retire(103);
      check_dispatch("rr_d1");
      retire(201); retire(202);
      push(2, 300); retire(203);
      check_dispatch("rr_d2");
      retire(301); retire(302);
      push(0, 103); retire(303);
      check_dispatch("rr_d0_again");

      // Single process re-dispatches itself with the saved PC
      do_reset();
      create(5, 40);
      quantum_cfg = 8'd2;
      push(5, 40);
      start_pulse();
      check_dispatch("self_d0");
      retire(41);
      push(5, 42); retire(42);
      check_dispatch("self_d1");

      // I/O block, exit, wait, wake
      do_reset();
      create(0, 10); create(1, 20);
      quantum_cfg = 8'd8;
      push(0, 10);
      start_pulse();
      check_dispatch("io_d0");
      io_block = 1'b1; retire_pc = 32'd57;
      push(1, 20);
      cyc();
      io_block = 1'b0;
      check_dispatch("io_d1");
      proc_exit = 1'b1;
      cyc();
      proc_exit = 1'b0;
      cyc();
      chk("io_waiting",     64'(waiting),       64'd1);
      chk("io_wait_vld",    64'(load_pc_valid), 64'd0);
      chk("io_wait_run",    64'(running),       64'd0);
      cyc();
      chk("io_waiting_hold", 64'(waiting),      64'd1);
      io_wake = 1'b1; io_wake_id = 3'd0;
      push(0, 57);
      cyc();
      io_wake = 1'b0;
      check_dispatch("io_wake");
      chk("io_not_waiting", 64'(waiting), 64'd0);

      // Simultaneous exit, block and expiring retire; then all done
      do_reset();
      create(0, 100); create(1, 200);
      quantum_cfg = 8'd1;
      push(0, 100);
      start_pulse();
      check_dispatch("pri_d0");
      proc_exit = 1'b1; io_block = 1'b1; instr_retire = 1'b1; retire_pc = 32'd999;
      push(1, 200);
      cyc();
      proc_exit = 1'b0; io_block = 1'b0; instr_retire = 1'b0;
      check_dispatch("pri_d1");
      push(1, 201); retire(201);
      check_dispatch("pri_only_id1");
      proc_exit = 1'b1;
      cyc();
      proc_exit = 1'b0;
      chk("done_select_vld", 64'(load_pc_valid), 64'd0);
      cyc();
      chk("done_flag",   64'(all_done),      64'd1);
      chk("done_vld",    64'(load_pc_valid), 64'd0);
      chk("done_running", 64'(running),      64'd0);
      for (int k = 0; k < 4; k++) cyc();
      chk("done_vld_hold",  64'(load_pc_valid), 64'd0);
      chk("done_flag_hold", 64'(all_done),      64'd1);

      // Quantum 0 behaves as 1
      do_reset();
      create(2, 500); create(4, 600);
      quantum_cfg = 8'd0;
      push(2, 500);
      start_pulse();
      check_dispatch("q0_d0");
      push(4, 600); retire(501);
      check_dispatch("q0_d1");
      push(2, 501); retire(601);
      check_dispatch("q0_d2");

      // Reset in RUN, then start with nothing created
      do_reset();
      create(3, 33);
      quantum_cfg = 8'd4;
      push(3, 33);
      start_pulse();
      check_dispatch("rst_run_d");
      retire(34);
      reset = 1'b1;
      cyc();
      chk("rst_run_vld",     64'(load_pc_valid), 64'd0);
      chk("rst_run_pc",      64'(load_pc),       64'd0);
      chk("rst_run_id",      64'(current_id),    64'd0);
      chk("rst_run_running", 64'(running),       64'd0);
      chk("rst_run_waiting", 64'(waiting),       64'd0);
      chk("rst_run_done",    64'(all_done),      64'd0);
      reset = 1'b0;
      cyc();
      chk("idle_hold_done", 64'(all_done), 64'd0);
      start_pulse();
      chk("empty_start_done", 64'(all_done),      64'd1);
      chk("empty_start_vld",  64'(load_pc_valid), 64'd0);
      cyc();
      chk("empty_start_vld2", 64'(load_pc_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
